// File: rtl/uart_byte_fifo.sv
// Byte FIFO between a UART receiver and sender, with a four-phase req/ack handshake on each side.
// Optional macro UART_FIFO_DROP_EN: when full, acknowledge and discard incoming bytes instead of stalling.
module uart_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_req,
  input  logic [7:0]    in_data,
  output logic          in_ack,
  output logic          out_req,
  output logic [7:0]    out_data,
  input  logic          out_ack,
  output logic [CW-1:0] count,
  output logic [7:0]    drop_cnt,
  output logic [2:0]    fsm_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake (both sides): req rises, ack rises, req falls, ack falls.
  // A byte moves only on the rising edge of ack; nothing else completes a transfer.
  typedef enum logic [0:0] {IN_IDLE, IN_WAIT} in_state_t;
  typedef enum logic [1:0] {OUT_IDLE, OUT_ACK, OUT_REL} out_state_t;

  in_state_t  in_state, in_next;
  out_state_t out_state, out_next;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty;
  logic          do_write, do_pop, do_load;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ack    = (in_state == IN_WAIT);
  assign out_req   = (out_state == OUT_ACK);
  assign fsm_state = {in_state, out_state};

`ifdef UART_FIFO_DROP_EN
  logic do_drop;
`endif

  always_comb begin
    in_next  = in_state;
    do_write = 1'b0;
`ifdef UART_FIFO_DROP_EN
    do_drop  = 1'b0;
`endif
    case (in_state)
      IN_IDLE: begin
        if (in_req) begin
          if (!full) begin
            do_write = 1'b1;
            in_next  = IN_WAIT;
          end
`ifdef UART_FIFO_DROP_EN
          else begin
            do_drop = 1'b1;
            in_next = IN_WAIT;
          end
`endif
        end
      end
      IN_WAIT: if (!in_req) in_next = IN_IDLE;
      default: in_next = IN_IDLE;
    endcase
  end

  always_comb begin
    out_next = out_state;
    do_load  = 1'b0;
    do_pop   = 1'b0;
    case (out_state)
      OUT_IDLE: begin
        if (!empty) begin
          do_load  = 1'b1;
          out_next = OUT_ACK;
        end
      end
      OUT_ACK: begin
        if (out_ack) begin
          do_pop   = 1'b1;
          out_next = OUT_REL;
        end
      end
      OUT_REL: if (!out_ack) out_next = OUT_IDLE;
      default: out_next = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      in_state  <= IN_IDLE;
      out_state <= OUT_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_data  <= 8'h00;
    end else begin
      in_state  <= in_next;
      out_state <= out_next;
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
      // out_data only loads in OUT_IDLE, so it is frozen for the whole request.
      if (do_load)  out_data <= mem[rd_ptr];
      case ({do_write, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= in_data;
  end

`ifdef UART_FIFO_DROP_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) drop_cnt <= 8'h00;
    else if (do_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'h01;
  end
`else
  assign drop_cnt = 8'h00;
`endif

endmodule

// File: doc/uart_byte_fifo.md
UART_BYTE_FIFO -- requirements
Module: uart_byte_fifo

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the number of byte entries; legal values are powers of two, 2 to 64.
REQ-002 Parameter CW, default 4, SHALL set the count width and SHALL equal log2(DEPTH)+1.
REQ-003 Port clk, input, 1 bit, SHALL be the single system clock; every register is clocked on its rising edge.
REQ-004 Port clr, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-005 Port in_req, input, 1 bit, SHALL be the upstream receiver's byte-ready request, synchronous to clk.
REQ-006 Port in_data, input, 8 bits, SHALL carry the received byte and is valid while in_req=1.
REQ-007 Port in_ack, output, 1 bit, SHALL acknowledge byte capture to the upstream receiver.
REQ-008 Port out_req, output, 1 bit, SHALL be the byte-ready request to the downstream sender.
REQ-009 Port out_data, output, 8 bits, SHALL carry the head byte and is stable while out_req=1.
REQ-010 Port out_ack, input, 1 bit, SHALL be the downstream sender's acknowledge, synchronous to clk.
REQ-011 Port count, output, CW bits, SHALL report the current occupancy, 0..DEPTH.
REQ-012 Port drop_cnt, output, 8 bits, SHALL report the number of bytes discarded while full.

Function
REQ-013 Both sides SHALL use a four-phase handshake: req up, ack up, req down, ack down.
REQ-014 Input FSM states SHALL be IN_IDLE and IN_WAIT.
REQ-015 IN_IDLE, in_req=1, count<DEPTH: SHALL write in_data at wr_ptr, increment wr_ptr, set in_ack=1 at the same edge, go to IN_WAIT.
REQ-016 IN_WAIT SHALL hold in_ack=1 until in_req=0 is sampled, then clear in_ack and return to IN_IDLE.
REQ-017 The output FSM SHALL use states OUT_IDLE, OUT_ACK and OUT_REL.
REQ-018 OUT_IDLE, count>0: SHALL load out_data from rd_ptr, set out_req=1, go to OUT_ACK.
REQ-019 OUT_ACK, out_ack=1: SHALL clear out_req, increment rd_ptr, decrement count, go to OUT_REL.
REQ-020 OUT_REL, out_ack=0: SHALL return to OUT_IDLE.
REQ-021 Latency: a byte written at edge k into an empty FIFO with OUT_IDLE SHALL raise out_req at edge k+1.
REQ-022 Pointers SHALL wrap modulo DEPTH; FIFO order SHALL be strictly preserved.
REQ-023 Simultaneous write and pop at one edge SHALL leave count unchanged.
REQ-024 Full SHALL be count==DEPTH and SHALL be evaluated on the registered count; a pop at the same edge does not enable a write until the next edge.
REQ-025 Empty SHALL be count==0; out_req SHALL never assert while empty.
REQ-026 out_data SHALL not change while out_req=1.

Reset
REQ-027 When clr=1: in_ack=0, out_req=0, out_data=8'h00, count=0, drop_cnt=0, both pointers=0, both FSMs idle, asynchronously.
REQ-028 Reset mid-handshake SHALL abandon the transfer; after clr falls, a still-high in_req SHALL be treated as a new byte.
REQ-029 Memory contents need not be reset.

Configuration
REQ-030 Macro UART_FIFO_DROP_EN defined: IN_IDLE with in_req=1 and count==DEPTH SHALL assert in_ack without writing and increment drop_cnt, saturating at 255.
REQ-031 Macro undefined: a full FIFO SHALL withhold in_ack (back-pressure) until count<DEPTH, and drop_cnt SHALL be constant 0.

Verification
REQ-032 Single byte: push 8'h41 into an empty FIFO -> in_ack high next edge, out_req high one edge later, out_data=8'h41, count returns to 0 after out_ack.
REQ-033 Order and wrap: push 20 bytes 8'h00..8'h13 with the sender acking immediately -> bytes received in order across pointer wrap.
REQ-034 Full, macro undefined: out_ack held low, push 9 bytes -> count=8, 9th in_ack withheld; one pop -> 9th accepted, no data lost.
REQ-035 Full, UART_FIFO_DROP_EN: push 10 bytes with no pops -> count=8, drop_cnt=2, output = first 8 bytes.
REQ-036 Simultaneous: count=3, write and pop at the same edge -> count stays 3.
REQ-037 Reset: assert clr while out_req=1 and count=5 -> out_req=0, count=0, drop_cnt=0 immediately.
